sender_control_par: RTL and testbench

SENDER_CONTROL_PAR -- requirements
Module: sender_control_par

---
 rtl/sender_control_par.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_sender_control_par.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sender_control_par.sv
// ---------------------------------------------------------------------------
// sender_control_par
//
// Word FIFO followed by a request/acknowledge serial sender. Words are
// enqueued with 'write'. A 'start' in IDLE, with at least one stored word,
// begins a burst. Each word in the burst goes through two phases:
//   - Request is raised and held until the receiver answers with Ack.
//   - The word is then shifted out on sdrDataOut, one bit per cycle,
//     optionally followed by an even-parity bit.
// The burst carries on while words remain in the FIFO when a word finishes.
// When the FIFO is empty at that point, 'done' pulses for one cycle.
//
// Parameters
//   DATA_W    : data word width (>= 2)
//   DEPTH     : FIFO depth in words (power of 2, >= 2)
//   MSB_FIRST : 1 = serialise MSB first, 0 = LSB first
//   PARITY    : 1 = append one even-parity bit after each word
//
// Ports
//   clk        in   single clock; all state updates on the rising edge
//   Reset      in   asynchronous, active-low reset
//   data       in   word to enqueue
//   write      in   enqueue 'data' this cycle
//   start      in   begin transmitting the FIFO contents
//   Ack        in   receiver acknowledge of Request
//   Request    out  per-word transfer request (registered)
//   sdrDataOut out  serial data (registered), 0 outside SHIFT
//   full       out  count == DEPTH
//   empty      out  count == 0
//   busy       out  FSM in REQ or SHIFT (registered)
//   done       out  one-cycle pulse at the end of a burst (registered)
//   overflow   out  sticky: a write was dropped because the FIFO was full
//   count      out  number of stored words
// ---------------------------------------------------------------------------
module sender_control_par #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int MSB_FIRST = 1,
  parameter int PARITY    = 0
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic [DATA_W-1:0]            data,
  input  logic                         write,
  input  logic                         start,
  input  logic                         Ack,
  output logic                         Request,
  output logic                         sdrDataOut,
  output logic                         full,
  output logic                         empty,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int NBITS = DATA_W + ((PARITY != 0) ? 1 : 0);
  localparam int BW    = $clog2(NBITS + 1);

  localparam bit            HAS_PAR  = (PARITY != 0);
  // Index of the last bit of a frame (data bits plus optional parity).
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
  // Index of the last data bit; the parity bit follows it when enabled.
  localparam logic [BW-1:0] LAST_DAT = BW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Even parity: the parity bit makes the total number of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    even_parity = ^w;
  endfunction

  // Bit that leaves the shift register next, depending on the bit order.
  function automatic logic out_bit(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) begin
      out_bit = w[DATA_W-1];
    end else begin
      out_bit = w[0];
    end
  endfunction

  // Shift register contents after one bit has been taken out.
  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) begin
      shift_word = {w[DATA_W-2:0], 1'b0};
    end else begin
      shift_word = {1'b0, w[DATA_W-1:1]};
    end
  endfunction

  // -------------------------------------------------------------------------
  // FIFO state
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              overflow_q, overflow_d;

  logic              full_s;
  logic              empty_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic [DATA_W-1:0] head_s;

  // -------------------------------------------------------------------------
  // Sender FSM state
  // -------------------------------------------------------------------------
  state_e            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic              par_q;
  logic [BW-1:0]     bit_cnt_q;
  logic              req_q;
  logic              sdr_q;
  logic              done_q;
  logic              busy_q;

  assign full_s  = (count_q == CNT_FULL);
  assign empty_s = (count_q == {CW{1'b0}});
  assign head_s  = mem_q[rd_ptr_q];

  // The only consumer of the FIFO is the acknowledged request.
  assign pop_s  = (state_q == ST_REQ) && Ack && !empty_s;
  // A full FIFO still accepts a write when a word leaves in the same cycle.
  assign push_s = write && (!full_s || pop_s);
  assign drop_s = write && full_s && !pop_s;

  // FIFO pointer, occupancy and overflow next-state logic.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop_s;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage. The array has no reset; the pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  // Sender FSM with registered Request, serial data, busy and done.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= {DATA_W{1'b0}};
      par_q     <= 1'b0;
      bit_cnt_q <= {BW{1'b0}};
      req_q     <= 1'b0;
      sdr_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sdr_q <= 1'b0;
          // start with an empty FIFO is ignored
          if (start && !empty_s) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        ST_REQ: begin
          // The head word moves into the shift register on the Ack edge,
          // and its first bit is driven from the very next cycle.
          if (pop_s) begin
            state_q   <= ST_SHIFT;
            req_q     <= 1'b0;
            shreg_q   <= shift_word(head_s);
            par_q     <= even_parity(head_s);
            bit_cnt_q <= {BW{1'b0}};
            sdr_q     <= out_bit(head_s);
          end else begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            sdr_q   <= 1'b0;
          end
        end

        ST_SHIFT: begin
          // bit_cnt_q is the index of the bit currently on sdrDataOut.
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_q <= {BW{1'b0}};
            sdr_q     <= 1'b0;
            // count_q no longer includes the word just sent, so any
            // nonzero value means more words, including ones written
            // during this transfer.
            if (!empty_s) begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (HAS_PAR && (bit_cnt_q == LAST_DAT)) begin
              sdr_q <= par_q;
            end else begin
              sdr_q   <= out_bit(shreg_q);
              shreg_q <= shift_word(shreg_q);
            end
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          req_q     <= 1'b0;
          sdr_q     <= 1'b0;
          busy_q    <= 1'b0;
          bit_cnt_q <= {BW{1'b0}};
        end
      endcase
    end
  end

  assign Request    = req_q;
  assign sdrDataOut = sdr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign count      = count_q;
  assign full       = full_s;
  assign empty      = empty_s;

endmodule

// File: tb/tb_sender_control_par.sv
// ---------------------------------------------------------------------------
// tb_sender_control_par
//
// Self-checking bench for sender_control_par. One instance uses the default
// parameters (16-bit words, depth 16, MSB first, no parity). A second
// instance uses LSB-first order with parity and depth 4. Words written to
// the main instance are pushed to a scoreboard queue. Each word received
// serially is assembled and compared against the next queue entry.
// ---------------------------------------------------------------------------
module tb_sender_control_par;

  logic        clk;
  logic        Reset;

  // default-parameter instance
  logic [15:0] data;
  logic        write, start, Ack;
  logic        Request, sdrDataOut, full, empty, busy, done, overflow;
  logic [4:0]  count;

  // parity / LSB-first instance
  logic [15:0] p_data;
  logic        p_write, p_start, p_ack;
  logic        p_req, p_sdr, p_full, p_empty, p_busy, p_done, p_ovf;
  logic [2:0]  p_count;

  int          n_vec;
  int          n_miss;
  logic [15:0] exp_q [$];

  sender_control_par dut (
    .clk        (clk),
    .Reset      (Reset),
    .data       (data),
    .write      (write),
    .start      (start),
    .Ack        (Ack),
    .Request    (Request),
    .sdrDataOut (sdrDataOut),
    .full       (full),
    .empty      (empty),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .count      (count)
  );

  sender_control_par #(
    .DATA_W    (16),
    .DEPTH     (4),
    .MSB_FIRST (0),
    .PARITY    (1)
  ) dut_p (
    .clk        (clk),
    .Reset      (Reset),
    .data       (p_data),
    .write      (p_write),
    .start      (p_start),
    .Ack        (p_ack),
    .Request    (p_req),
    .sdrDataOut (p_sdr),
    .full       (p_full),
    .empty      (p_empty),
    .busy       (p_busy),
    .done       (p_done),
    .overflow   (p_ovf),
    .count      (p_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helper: counts every comparison and reports mismatches.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Enqueue one word into the main instance and keep the model in step.
  task automatic wr(input logic [15:0] d);
    write = 1'b1;
    data  = d;
    if (exp_q.size() < 16) exp_q.push_back(d);
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for Request, hold off Ack for one cycle, acknowledge, then assemble
  // 16 MSB-first bits and compare against the scoreboard. When wr_at is in
  // 0..14, a new word is written while that bit is on the line.
  task automatic recv_word(input int wr_at, input logic [15:0] wr_data);
    int          n;
    logic [15:0] w;
    logic [15:0] e;
    n = 0;
    while (Request !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, Request}, 32'd1);
    if (Request !== 1'b1) return;
    check("sdr_in_req", {31'd0, sdrDataOut}, 32'd0);
    check("busy_in_req", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("req_held", {31'd0, Request}, 32'd1);
    Ack = 1'b1;
    @(negedge clk);
    Ack = 1'b0;
    check("req_drop", {31'd0, Request}, 32'd0);
    w = 16'd0;
    for (int i = 0; i < 16; i++) begin
      w = {w[14:0], sdrDataOut};
      if (i == wr_at) begin
        write = 1'b1;
        data  = wr_data;
        exp_q.push_back(wr_data);
      end else begin
        write = 1'b0;
      end
      @(negedge clk);
    end
    write = 1'b0;
    check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'd0;
    check("word", {16'd0, w}, {16'd0, e});
    check("sdr_after", {31'd0, sdrDataOut}, 32'd0);
  endtask

  // Check the burst-end state and that done lasts exactly one cycle.
  task automatic end_burst();
    check("done_pulse", {31'd0, done}, 32'd1);
    check("end_count", {27'd0, count}, 32'd0);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_req", {31'd0, Request}, 32'd0);
    @(negedge clk);
    check("done_clear", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pw;
    logic        eb;
    int          n;
    n_vec   = 0;
    n_miss  = 0;
    Reset   = 1'b0;
    write   = 1'b1;
    data    = 16'hBEEF;
    start   = 1'b0;
    Ack     = 1'b0;
    p_data  = 16'd0;
    p_write = 1'b0;
    p_start = 1'b0;
    p_ack   = 1'b0;

    // Reset is held while write is asserted: nothing is stored.
    repeat (3) @(negedge clk);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_req", {31'd0, Request}, 32'd0);
    check("rst_sdr", {31'd0, sdrDataOut}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    write = 1'b0;

    // Release reset; the write on the first following edge is accepted.
    Reset = 1'b1;
    wr(16'h1000);
    check("first_write", {27'd0, count}, 32'd1);
    wr(16'h1001);
    wr(16'h1002);
    check("three_count", {27'd0, count}, 32'd3);
    pulse_start();
    recv_word(-1, 16'd0);
    recv_word(-1, 16'd0);
    recv_word(-1, 16'd0);
    end_burst();

    // Fill to 16, drop the 17th, then send exactly the 16 stored words.
    for (int i = 0; i < 16; i++) wr(16'h1000 + 16'(i));
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_ovf", {31'd0, overflow}, 32'd0);
    check("fill_count", {27'd0, count}, 32'd16);
    wr(16'h10FF);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_count", {27'd0, count}, 32'd16);
    check("ovf_full", {31'd0, full}, 32'd1);
    pulse_start();
    for (int i = 0; i < 16; i++) recv_word(-1, 16'd0);
    end_burst();
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("burst_empty", {31'd0, empty}, 32'd1);

    // A word written during the last word's SHIFT joins the same burst.
    wr(16'h1234);
    pulse_start();
    recv_word(5, 16'h2000);
    check("no_done_mid", {31'd0, done}, 32'd0);
    recv_word(-1, 16'd0);
    end_burst();

    // Reset during the second of four words aborts everything.
    for (int i = 0; i < 4; i++) wr(16'hA000 + 16'(i));
    pulse_start();
    recv_word(-1, 16'd0);
    n = 0;
    while (Request !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("w2_req", {31'd0, Request}, 32'd1);
    Ack = 1'b1;
    @(negedge clk);
    Ack = 1'b0;
    repeat (4) @(negedge clk);
    #2 Reset = 1'b0;
    #1;
    check("abort_req", {31'd0, Request}, 32'd0);
    check("abort_sdr", {31'd0, sdrDataOut}, 32'd0);
    check("abort_count", {27'd0, count}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ovf", {31'd0, overflow}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      check("empty_start_req", {31'd0, Request}, 32'd0);
      check("empty_start_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end

    // LSB-first with an even-parity bit appended to each word.
    p_write = 1'b1;
    p_data  = 16'h0007;
    @(negedge clk);
    p_data  = 16'h1235;
    @(negedge clk);
    p_write = 1'b0;
    check("p_count", {29'd0, p_count}, 32'd2);
    p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pw = (k == 0) ? 16'h0007 : 16'h1235;
      n = 0;
      while (p_req !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("p_req", {31'd0, p_req}, 32'd1);
      check("p_sdr_req", {31'd0, p_sdr}, 32'd0);
      p_ack = 1'b1;
      @(negedge clk);
      p_ack = 1'b0;
      for (int i = 0; i < 17; i++) begin
        eb = (i < 16) ? pw[i] : ^pw;
        check($sformatf("p_bit%0d_%0d", k, i), {31'd0, p_sdr}, {31'd0, eb});
        @(negedge clk);
      end
    end
    check("p_done", {31'd0, p_done}, 32'd1);
    check("p_sdr_idle", {31'd0, p_sdr}, 32'd0);
    check("p_empty", {31'd0, p_empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
